// File: rtl/phy_rx_lane_destripe.sv
// Receive-side lane de-striper for the 4-lane PHY.
// Locks onto the COM framing symbol in a serialized byte stream, then un-stripes the following
// bytes round-robin into four 8-bit lanes and presents each complete group with a 1-cycle valid.
// Optional feature: define PHYRX_SKP_DROP_EN to discard SKP_SYM bytes while aligned.
module phy_rx_lane_destripe #(
  parameter logic [7:0]  COM_SYM = 8'hBC,
  parameter logic [7:0]  SKP_SYM = 8'h1C,
  parameter int unsigned GAP_MAX = 8
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic       valid_out,
  output logic       aligned,
  output logic       partial_drop,
  output logic       sync_lost
);

  localparam logic [7:0] GapMax = 8'(GAP_MAX);

  typedef enum logic [0:0] {StSearch, StAligned} state_e;

  state_e          state_q, state_d;
  logic [1:0]      lane_q, lane_d;
  logic [7:0]      gap_q, gap_d;
  // Only lanes 0..2 need holding; the 4th byte goes straight to the output register.
  logic [2:0][7:0] slot_q, slot_d;
  logic [3:0][7:0] out_q, out_d;
  logic            valid_out_q, valid_out_d;
  logic            pdrop_q, pdrop_d;
  logic            slost_q, slost_d;

  logic            com_hit;
  logic            skp_hit;

  assign com_hit = (data_in == COM_SYM);

`ifdef PHYRX_SKP_DROP_EN
  assign skp_hit = (data_in == SKP_SYM);
`else
  logic unused_skp;
  assign unused_skp = ^SKP_SYM;
  assign skp_hit    = 1'b0;
`endif

  // Next-state: framing search, lane striping, realign and gap timeout.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    gap_d       = gap_q;
    slot_d      = slot_q;
    out_d       = out_q;
    valid_out_d = 1'b0;
    pdrop_d     = 1'b0;
    slost_d     = 1'b0;

    unique case (state_q)
      StSearch: begin
        if (valid_in && com_hit) begin
          state_d = StAligned;
          lane_d  = 2'd0;
          gap_d   = 8'd0;
          slot_d  = '0;
        end
      end
      StAligned: begin
        if (valid_in) begin
          // Any valid byte (COM, SKP or data) counts as link activity.
          gap_d = 8'd0;
          if (com_hit) begin
            pdrop_d = (lane_q != 2'd0);
            lane_d  = 2'd0;
            slot_d  = '0;
          end else if (!skp_hit) begin
            if (lane_q == 2'd3) begin
              out_d       = {data_in, slot_q[2], slot_q[1], slot_q[0]};
              valid_out_d = 1'b1;
              slot_d      = '0;
            end else begin
              for (int i = 0; i < 3; i++) begin
                if (lane_q == 2'(i)) slot_d[i] = data_in;
              end
            end
            lane_d = lane_q + 2'd1;
          end
        end else if (gap_q >= GapMax) begin
          // GAP_MAX idle cycles already counted and this one is idle too.
          state_d = StSearch;
          lane_d  = 2'd0;
          gap_d   = 8'd0;
          slot_d  = '0;
          slost_d = 1'b1;
        end else if (gap_q != 8'hFF) begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  // State and registered outputs; async reset drops any partial group silently.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= StSearch;
      lane_q      <= 2'd0;
      gap_q       <= 8'd0;
      slot_q      <= '0;
      out_q       <= '0;
      valid_out_q <= 1'b0;
      pdrop_q     <= 1'b0;
      slost_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      gap_q       <= gap_d;
      slot_q      <= slot_d;
      out_q       <= out_d;
      valid_out_q <= valid_out_d;
      pdrop_q     <= pdrop_d;
      slost_q     <= slost_d;
    end
  end

  assign out0         = out_q[0];
  assign out1         = out_q[1];
  assign out2         = out_q[2];
  assign out3         = out_q[3];
  assign valid_out    = valid_out_q;
  assign aligned      = (state_q == StAligned);
  assign partial_drop = pdrop_q;
  assign sync_lost    = slost_q;

endmodule

// File: tb/tb_phy_rx_lane_destripe.sv
// Bench for phy_rx_lane_destripe: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based model of the framing rules.
module tb_phy_rx_lane_destripe;

  localparam logic [7:0] Com = 8'hBC;
  localparam logic [7:0] Skp = 8'h1C;
  localparam int         Gap = 8;
`ifdef PHYRX_SKP_DROP_EN
  localparam bit SkpEn = 1'b1;
`else
  localparam bit SkpEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic [7:0] out0, out1, out2, out3;
  logic       valid_out, aligned, partial_drop, sync_lost;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  phy_rx_lane_destripe #(
    .COM_SYM(Com),
    .SKP_SYM(Skp),
    .GAP_MAX(Gap)
  ) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .valid_out   (valid_out),
    .aligned     (aligned),
    .partial_drop(partial_drop),
    .sync_lost   (sync_lost)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] e_out [4];
  logic       e_vo, e_al, e_pd, e_sl;
  bit         m_sync;
  byte        part[$];
  int         idle;

  initial begin
    forever begin
      @(posedge clk or negedge reset_L);
      if (!reset_L) begin
        m_sync = 0; part.delete(); idle = 0;
        for (int i = 0; i < 4; i++) e_out[i] = 8'h00;
        e_vo = 0; e_al = 0; e_pd = 0; e_sl = 0;
      end else begin
        e_vo = 0; e_pd = 0; e_sl = 0;
        if (!m_sync) begin
          if (valid_in && data_in == Com) begin
            m_sync = 1; part.delete(); idle = 0;
          end
        end else if (valid_in) begin
          idle = 0;
          if (data_in == Com) begin
            if (part.size() != 0) e_pd = 1;
            part.delete();
          end else if (!(SkpEn && data_in == Skp)) begin
            part.push_back(data_in);
            if (part.size() == 4) begin
              for (int i = 0; i < 4; i++) e_out[i] = part[i];
              e_vo = 1;
              part.delete();
            end
          end
        end else begin
          idle++;
          if (idle > Gap) begin
            m_sync = 0; e_sl = 1; part.delete(); idle = 0;
          end
        end
        e_al = m_sync;
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("m.out0", out0, e_out[0]);
        chk("m.out1", out1, e_out[1]);
        chk("m.out2", out2, e_out[2]);
        chk("m.out3", out3, e_out[3]);
        chk("m.valid_out", {7'd0, valid_out}, {7'd0, e_vo});
        chk("m.aligned", {7'd0, aligned}, {7'd0, e_al});
        chk("m.partial_drop", {7'd0, partial_drop}, {7'd0, e_pd});
        chk("m.sync_lost", {7'd0, sync_lost}, {7'd0, e_sl});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_L  = 1'b0;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;
  endtask

  task automatic chk_grp(input string nm, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    chk({nm, ".out0"}, out0, a);
    chk({nm, ".out1"}, out1, b);
    chk({nm, ".out2"}, out2, c);
    chk({nm, ".out3"}, out3, d);
  endtask

  initial begin
    int r;
    int n;
    do_reset();
    chk_en = 1'b1;
    chk_grp("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("rst.aligned", {7'd0, aligned}, 8'h00);
    chk("rst.valid_out", {7'd0, valid_out}, 8'h00);

    // 1: basic lock and group
    send(1, Com);
    chk("t1.aligned", {7'd0, aligned}, 8'h01);
    send(1, 8'h01); send(1, 8'h02); send(1, 8'h03);
    chk("t1.no_valid_early", {7'd0, valid_out}, 8'h00);
    send(1, 8'h04);
    chk_grp("t1", 8'h01, 8'h02, 8'h03, 8'h04);
    chk("t1.valid_out", {7'd0, valid_out}, 8'h01);
    send(0, 8'h00);
    chk("t1.valid_pulse", {7'd0, valid_out}, 8'h00);
    chk("t1.hold", out3, 8'h04);

    // 2: no COM, no lock
    do_reset();
    send(1, 8'h11); send(1, 8'h22); send(1, 8'h33);
    chk("t2.aligned", {7'd0, aligned}, 8'h00);
    chk("t2.out0", out0, 8'h00);

    // 3: realign mid-group
    do_reset();
    send(1, Com); send(1, 8'h01); send(1, 8'h02); send(1, Com);
    chk("t3.partial_drop", {7'd0, partial_drop}, 8'h01);
    send(1, 8'h05);
    chk("t3.pd_pulse", {7'd0, partial_drop}, 8'h00);
    send(1, 8'h06); send(1, 8'h07); send(1, 8'h08);
    chk_grp("t3", 8'h05, 8'h06, 8'h07, 8'h08);
    chk("t3.valid_out", {7'd0, valid_out}, 8'h01);

    // 4: tolerated gap, then timeout
    do_reset();
    send(1, Com); send(1, 8'h01); send(1, 8'h02);
    repeat (3) send(0, 8'h00);
    send(1, 8'h03); send(1, 8'h04);
    chk_grp("t4", 8'h01, 8'h02, 8'h03, 8'h04);
    repeat (8) send(0, 8'h00);
    chk("t4.no_loss_yet", {7'd0, sync_lost}, 8'h00);
    chk("t4.still_aligned", {7'd0, aligned}, 8'h01);
    send(0, 8'h00);
    chk("t4.sync_lost", {7'd0, sync_lost}, 8'h01);
    chk("t4.aligned_drop", {7'd0, aligned}, 8'h00);
    send(1, 8'h05); send(1, 8'h06); send(1, 8'h07); send(1, 8'h08);
    chk("t4.ignored", {7'd0, valid_out}, 8'h00);
    chk("t4.out0_kept", out0, 8'h01);

    // 5: async reset mid-stream
    send(1, Com); send(1, 8'h01); send(1, 8'h02); send(1, 8'h03); send(1, 8'h04);
    send(1, Com); send(1, 8'h01); send(1, 8'h02); send(1, 8'h03);
    #2 reset_L = 1'b0;
    #1;
    chk("t5.async_out0", out0, 8'h00);
    chk("t5.async_aligned", {7'd0, aligned}, 8'h00);
    @(posedge clk);
    #1 reset_L = 1'b1;
    send(1, Com); send(1, 8'h0A); send(1, 8'h0B); send(1, 8'h0C); send(1, 8'h0D);
    chk_grp("t5", 8'h0A, 8'h0B, 8'h0C, 8'h0D);
    chk("t5.pd_none", {7'd0, partial_drop}, 8'h00);

    // 6: SKP handling
    do_reset();
    send(1, Com); send(1, 8'h01); send(1, Skp); send(1, 8'h02); send(1, 8'h03);
    if (SkpEn) begin
      send(1, 8'h04);
      chk_grp("t6skp", 8'h01, 8'h02, 8'h03, 8'h04);
    end else begin
      chk_grp("t6raw", 8'h01, Skp, 8'h02, 8'h03);
      send(1, 8'h04);
      send(1, Com);
      chk("t6raw.leftover", {7'd0, partial_drop}, 8'h01);
    end

    // Random traffic, model-checked every cycle
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        n = $urandom_range(5, 12);
        repeat (n) send(0, 8'($urandom));
      end else if (r < 25) send(0, 8'($urandom));
      else if (r < 35) send(1, Com);
      else if (r < 42) send(1, Skp);
      else if (r < 43) do_reset();
      else send(1, 8'($urandom));
    end
    send(0, 8'h00);
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
